// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: ALU control codes and FSM state encoding.
package alu_arb_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arbState_e;

endpackage

// File: rtl/alu_rr_picker.sv
// Two-way round-robin picker: a lone valid requester wins, a tie goes to the one
// that did not win last.
module alu_rr_picker (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  assign any   = |valid;
  assign grant = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one N-bit ALU between two requesters with round-robin grant.
// Optional grant statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = 16
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Req0Valid,
  output logic         Req0Ready,
  input  logic [N-1:0] Req0A,
  input  logic [N-1:0] Req0B,
  input  logic [3:0]   Req0Ctrl,
  input  logic         Req1Valid,
  output logic         Req1Ready,
  input  logic [N-1:0] Req1A,
  input  logic [N-1:0] Req1B,
  input  logic [3:0]   Req1Ctrl,
  output logic         RespValid,
  input  logic         RespReady,
  output logic         RespId,
  output logic [N-1:0] RespW,
  output logic         RespZero,
  output logic [N-1:0] AluBusA,
  output logic [N-1:0] AluBusB,
  output logic [3:0]   AluCtrl,
  input  logic [N-1:0] AluBusW,
  input  logic         AluZero,
  output logic [1:0]   DbgState
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CW-1:0] Grant0Count,
  output logic [CW-1:0] Grant1Count
`endif
);

  // Handshakes: a request transfers on a rising edge where Valid and Ready are both 1;
  // the response transfers on a rising edge where RespValid and RespReady are both 1.
  // Ready depends combinationally on Valid, never the other way round.

  arbState_e state, nextState;
  logic      lastGrant;
  logic      grant;
  logic      anyValid;
  logic      accept;

  alu_rr_picker uPicker (
    .valid ({Req1Valid, Req0Valid}),
    .last  (lastGrant),
    .grant (grant),
    .any   (anyValid)
  );

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    Req0Ready = 1'b0;
    Req1Ready = 1'b0;
    case (state)
      IDLE: begin
        if (anyValid) begin
          accept    = 1'b1;
          Req0Ready = ~grant;
          Req1Ready = grant;
          nextState = EXEC;
        end
      end
      EXEC:    nextState = RESP;
      RESP:    if (RespReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly so its inputs are glitch-free during EXEC.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      RespId    <= 1'b0;
      RespValid <= 1'b0;
      RespW     <= '0;
      RespZero  <= 1'b0;
      AluBusA   <= '0;
      AluBusB   <= '0;
      AluCtrl   <= 4'b0000;
    end else begin
      state <= nextState;
      if (accept) begin
        AluBusA   <= grant ? Req1A    : Req0A;
        AluBusB   <= grant ? Req1B    : Req0B;
        AluCtrl   <= grant ? Req1Ctrl : Req0Ctrl;
        lastGrant <= grant;
        RespId    <= grant;
      end
      if (state == EXEC) begin
        RespW     <= AluBusW;
        RespZero  <= AluZero;
        RespValid <= 1'b1;
      end else if (state == RESP && RespReady) begin
        RespValid <= 1'b0;
      end
    end
  end

  assign DbgState = state;

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester accept counters.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Grant0Count <= '0;
      Grant1Count <= '0;
    end else if (accept) begin
      if (!grant && !(&Grant0Count)) Grant0Count <= Grant0Count + 1'b1;
      if (grant && !(&Grant1Count))  Grant1Count <= Grant1Count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the ALU ports.
// Grant statistics are checked only when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

  localparam int N  = 64;
  localparam int CW = 2;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic         Req0Ready, Req1Ready;
  logic [N-1:0] Req0A = '0, Req0B = '0, Req1A = '0, Req1B = '0;
  logic [3:0]   Req0Ctrl = 4'b0, Req1Ctrl = 4'b0;
  logic         RespValid, RespId, RespZero;
  logic         RespReady = 1'b0;
  logic [N-1:0] RespW, AluBusA, AluBusB, AluBusW;
  logic [3:0]   AluCtrl;
  logic         AluZero;
  logic [1:0]   DbgState;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] Grant0Count, Grant1Count;
`endif

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.N(N), .CW(CW)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B), .Req0Ctrl(Req0Ctrl),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B), .Req1Ctrl(Req1Ctrl),
    .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId), .RespW(RespW), .RespZero(RespZero),
    .AluBusA(AluBusA), .AluBusB(AluBusB), .AluCtrl(AluCtrl), .AluBusW(AluBusW), .AluZero(AluZero),
    .DbgState(DbgState)
`ifdef ALU_ARB_STATS_EN
    , .Grant0Count(Grant0Count), .Grant1Count(Grant1Count)
`endif
  );

  // Clock and behavioural ALU
  always #5 CLK = ~CLK;

  always_comb begin
    case (AluCtrl)
      4'b0000: AluBusW = AluBusA & AluBusB;
      4'b0001: AluBusW = AluBusA | AluBusB;
      4'b0010: AluBusW = AluBusA + AluBusB;
      4'b0110: AluBusW = AluBusA - AluBusB;
      4'b0111: AluBusW = AluBusB;
      default: AluBusW = '0;
    endcase
  end
  assign AluZero = (AluBusW == '0);

  // Driver tasks
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; step(); step(); Reset = 1'b0; #1;
  endtask

  task automatic wait_resp();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (RespValid === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL resp_timeout: RespValid=%b required 1", RespValid); end
  endtask

  task automatic handshake();
    RespReady = 1'b1; step(); RespReady = 1'b0;
  endtask

  task automatic do_op(input bit who, input logic [3:0] ctrl, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic id, output logic [N-1:0] w, output logic z);
    bit acc = 1'b0;
    if (who) begin Req1Valid = 1'b1; Req1A = a; Req1B = b; Req1Ctrl = ctrl; end
    else     begin Req0Valid = 1'b1; Req0A = a; Req0B = b; Req0Ctrl = ctrl; end
    #1;
    for (int i = 0; i < 20 && !acc; i++) begin
      if ((who && Req1Ready) || (!who && Req0Ready)) acc = 1'b1;
      step();
    end
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    total++;
    if (!acc) begin bad++; $display("FAIL accept_timeout: requester %0d never granted", who); end
    wait_resp();
    id = RespId; w = RespW; z = RespZero;
    handshake();
  endtask

  // Scenarios
  task automatic test_reset();
    Reset = 1'b1; #2;
    total++; if (RespValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", RespValid); end
    total++; if (RespW !== '0) begin bad++; $display("FAIL reset_w: got %h exp 0", RespW); end
    total++; if (RespId !== 1'b0 || RespZero !== 1'b0) begin bad++; $display("FAIL reset_id_zero: got %b/%b exp 0/0", RespId, RespZero); end
    total++; if (AluBusA !== '0 || AluBusB !== '0 || AluCtrl !== 4'b0) begin bad++; $display("FAIL reset_alu: got %h %h %h exp 0", AluBusA, AluBusB, AluCtrl); end
    total++; if (DbgState !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d exp 0", DbgState); end
    step(); Reset = 1'b0; #1;
  endtask

  task automatic test_single_op();
    Req0Valid = 1'b1; Req0A = 64'd5; Req0B = 64'd7; Req0Ctrl = 4'b0010; #1;
    total++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin bad++; $display("FAIL single_ready: got %b%b exp 01", Req1Ready, Req0Ready); end
    step(); Req0Valid = 1'b0;
    total++; if (RespValid !== 1'b0 || DbgState !== 2'd1) begin bad++; $display("FAIL single_exec: valid=%b state=%0d exp 0/1", RespValid, DbgState); end
    total++; if (AluBusA !== 64'd5 || AluBusB !== 64'd7 || AluCtrl !== 4'b0010) begin bad++; $display("FAIL single_alu: got %h %h %h exp 5 7 2", AluBusA, AluBusB, AluCtrl); end
    step();
    total++; if (RespValid !== 1'b1) begin bad++; $display("FAIL single_latency: RespValid=%b exp 1", RespValid); end
    total++; if (RespW !== 64'd12 || RespZero !== 1'b0 || RespId !== 1'b0) begin bad++; $display("FAIL single_resp: got w=%h z=%b id=%b exp c/0/0", RespW, RespZero, RespId); end
    handshake();
    total++; if (RespValid !== 1'b0 || DbgState !== 2'd0) begin bad++; $display("FAIL single_done: valid=%b state=%0d exp 0/0", RespValid, DbgState); end
  endtask

  task automatic test_contention();
    do_reset();
    Req0Valid = 1'b1; Req0A = 64'd9; Req0B = 64'd9; Req0Ctrl = 4'b0110;
    Req1Valid = 1'b1; Req1A = 64'hF0; Req1B = 64'h0F; Req1Ctrl = 4'b0001; #1;
    total++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin bad++; $display("FAIL cont_first: got %b%b exp 01", Req1Ready, Req0Ready); end
    step(); Req0Valid = 1'b0;
    total++; if (Req1Ready !== 1'b0) begin bad++; $display("FAIL cont_exec_ready: got %b exp 0", Req1Ready); end
    wait_resp();
    total++; if (RespId !== 1'b0 || RespW !== '0 || RespZero !== 1'b1) begin bad++; $display("FAIL cont_resp0: got id=%b w=%h z=%b exp 0/0/1", RespId, RespW, RespZero); end
    handshake();
    total++; if (Req1Ready !== 1'b1) begin bad++; $display("FAIL cont_second: Req1Ready=%b exp 1", Req1Ready); end
    step(); Req1Valid = 1'b0;
    wait_resp();
    total++; if (RespId !== 1'b1 || RespW !== 64'hFF || RespZero !== 1'b0) begin bad++; $display("FAIL cont_resp1: got id=%b w=%h z=%b exp 1/ff/0", RespId, RespW, RespZero); end
    handshake();
  endtask

  task automatic test_fairness();
    Req0Valid = 1'b1; Req0A = 64'd1; Req0B = 64'd1; Req0Ctrl = 4'b0010;
    Req1Valid = 1'b1; Req1A = 64'd0; Req1B = 64'd3; Req1Ctrl = 4'b0111;
    RespReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic expId;
      logic [N-1:0] expW;
      expId = (i % 2 == 1);
      expW  = expId ? 64'd3 : 64'd2;
      wait_resp();
      total++; if (RespId !== expId || RespW !== expW) begin bad++; $display("FAIL fair_op%0d: got id=%b w=%h exp id=%b w=%h", i, RespId, RespW, expId, expW); end
      step();
    end
    Req0Valid = 1'b0; Req1Valid = 1'b0; RespReady = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    Req1Valid = 1'b1; Req1A = '0; Req1B = 64'hABCD; Req1Ctrl = 4'b0111; #1;
    step(); Req1Valid = 1'b0;
    Req0Valid = 1'b1; Req0A = '0; Req0B = '0; Req0Ctrl = 4'b0000;
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (RespValid !== 1'b1 || RespW !== 64'hABCD || RespId !== 1'b1 || Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b w=%h id=%b rdy=%b%b exp 1/abcd/1/00", i, RespValid, RespW, RespId, Req1Ready, Req0Ready);
      end
      step();
    end
    handshake(); Req0Valid = 1'b0;
    total++; if (RespValid !== 1'b0) begin bad++; $display("FAIL bp_release: RespValid=%b exp 0", RespValid); end
    step();
  endtask

  task automatic test_illegal_code();
    logic id, z;
    logic [N-1:0] w;
    do_op(1'b0, 4'b1111, '1, '1, id, w, z);
    total++; if (w !== '0 || z !== 1'b1 || id !== 1'b0) begin bad++; $display("FAIL illegal: got w=%h z=%b id=%b exp 0/1/0", w, z, id); end
  endtask

  task automatic test_reset_midop();
    Req0Valid = 1'b1; Req0A = 64'd1; Req0B = 64'd2; Req0Ctrl = 4'b0010; #1;
    step(); Req0Valid = 1'b0;
    total++; if (DbgState !== 2'd1) begin bad++; $display("FAIL rst_pre_exec: state=%0d exp 1", DbgState); end
    Reset = 1'b1; #1;
    total++; if (DbgState !== 2'd0 || RespValid !== 1'b0 || AluBusA !== '0) begin bad++; $display("FAIL rst_exec: state=%0d v=%b a=%h exp 0/0/0", DbgState, RespValid, AluBusA); end
    Reset = 1'b0; step(); step(); step();
    total++; if (RespValid !== 1'b0) begin bad++; $display("FAIL rst_discard: RespValid=%b exp 0", RespValid); end
    Req0Valid = 1'b1; #1; step(); Req0Valid = 1'b0; step();
    total++; if (RespValid !== 1'b1) begin bad++; $display("FAIL rst_pre_resp: RespValid=%b exp 1", RespValid); end
    Reset = 1'b1; #1;
    total++; if (RespValid !== 1'b0 || DbgState !== 2'd0) begin bad++; $display("FAIL rst_resp: v=%b state=%0d exp 0/0", RespValid, DbgState); end
    Reset = 1'b0; #1;
    Req1Valid = 1'b1; Req1A = 64'd20; Req1B = 64'd22; Req1Ctrl = 4'b0010; #1;
    total++; if (Req1Ready !== 1'b1 || Req0Ready !== 1'b0) begin bad++; $display("FAIL rst_req1_ready: got %b%b exp 10", Req1Ready, Req0Ready); end
    step(); Req1Valid = 1'b0;
    wait_resp();
    total++; if (RespId !== 1'b1 || RespW !== 64'd42) begin bad++; $display("FAIL rst_req1_resp: got id=%b w=%h exp 1/2a", RespId, RespW); end
    handshake();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    logic id, z;
    logic [N-1:0] w;
    do_reset();
    total++; if (Grant0Count !== '0 || Grant1Count !== '0) begin bad++; $display("FAIL stats_reset: got %0d/%0d exp 0/0", Grant0Count, Grant1Count); end
    for (int i = 0; i < 3; i++) do_op(1'b0, 4'b0010, 64'd1, 64'd1, id, w, z);
    for (int i = 0; i < 2; i++) do_op(1'b1, 4'b0010, 64'd1, 64'd1, id, w, z);
    total++; if (Grant0Count !== 2'd3 || Grant1Count !== 2'd2) begin bad++; $display("FAIL stats_count: got %0d/%0d exp 3/2", Grant0Count, Grant1Count); end
    for (int i = 0; i < 2; i++) do_op(1'b0, 4'b0010, 64'd1, 64'd1, id, w, z);
    total++; if (Grant0Count !== 2'd3 || Grant1Count !== 2'd2) begin bad++; $display("FAIL stats_saturate: got %0d/%0d exp 3/2", Grant0Count, Grant1Count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_fairness();
    test_backpressure();
    test_illegal_code();
    test_reset_midop();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
